pcma_signal_combiner: RTL and testbench
=======================================

Name: pcma_signal_combiner

Overview:
Transmit-side counterpart of the PCMA compensator. It builds the composite PCMA signal by passing the upper-signal symbols through a complex FIR channel model and adding the lower-signal symbols. The result is sum = low + h*up. It feeds the compensator's comm and data inputs in loopback benches and channel-emulation builds. FIR taps are loaded through the same preset/load interface the equalizer uses.

Parameters:
IQ_WIDTH, 10, width of the signed upper and lower input samples
COE_WIDTH, 16, width of each signed tap component; unity gain is 2^(COE_WIDTH-3)-1 = 8191
CH_LEN, 5, number of complex channel taps (2..16)
OUT_D_WIDTH, 12, width of the signed saturated sum output

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
iq_val  in  1  input symbol valid
i_up_I / i_up_Q  in  IQ_WIDTH each  upper signal, signed
i_low_I / i_low_Q  in  IQ_WIDTH each  lower signal, signed
preset_coe  in  1  active bank <= unity impulse (tap0 = 8191+j0, others 0)
load_coe  in  1  write one tap into the shadow bank; pulsed CH_LEN times, tap0 first
i_coe_I / i_coe_Q  in  COE_WIDTH each  tap value, sampled when load_coe=1
o_sum_I / o_sum_Q  out  OUT_D_WIDTH each  composite output
o_up_I / o_up_Q  out  IQ_WIDTH each  upper sample x[n], aligned with o_sum
o_vld  out  1  output valid
o_sat  out  1  sticky saturation flag
o_coe_busy  out  1  high while a partial load is in progress (pointer != 0)

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0;
  - delay line and pipeline cleared;
  - active bank = unity impulse;
  - shadow bank = 0;
  - load pointer = 0;
  - o_sat = 0.
- Delay line: CH_LEN complex registers, x[n]..x[n-CH_LEN+1].
  - Shifts only on cycles with iq_val=1.
  - Holds otherwise; gaps in iq_val do not insert zeros.
- Pipeline is a fixed 4-cycle latency from the iq_val sample edge to o_vld. It advances every clock; valid propagates alongside.
  - S1: register inputs and shift the delay line.
  - S2: 4*CH_LEN real products, each IQ_WIDTH+COE_WIDTH bits. Active bank is sampled here.
  - S3: complex accumulate. yI = sum(hI*xI - hQ*xQ), yQ = sum(hI*xQ + hQ*xI). Accumulator width IQ_WIDTH+COE_WIDTH+1+clog2(CH_LEN); no internal overflow allowed.
  - S4: round half-up (add 2^12, arithmetic shift right by 13); add the lower sample, delayed to match; saturate symmetrically to ±(2^(OUT_D_WIDTH-1)-1).
- o_up_I/o_up_Q: x[n] delayed to align with o_sum.
- o_sum and o_up hold their last values when o_vld=0.
- o_sat: set on any saturating S4 result while valid; cleared only by reset.
- Load FSM, states IDLE and LOADING:
  - Each load_coe writes shadow[ptr] and increments ptr.
  - On the CH_LEN-th write, ptr wraps to 0 and the FSM returns to IDLE.
  - The whole shadow bank copies to the active bank on the next clock edge, atomically.
  - S2 products in later cycles use the new taps; no mixed-bank result is allowed.
  - o_coe_busy = (ptr != 0).
- preset_coe:
  - Forces active = unity impulse, ptr = 0, state IDLE.
  - Discards any partial shadow load.
  - Has priority over a simultaneous load_coe, which is ignored.
  - Data in flight past S2 is unaffected.
- Reset mid-operation: in-flight valids are dropped; o_vld is 0 in the cycle after reset is sampled.
- iq_val together with load_coe or preset_coe: both take effect independently; the data path never stalls.

Test Plan:
1. Reset, no load; up=(100,-50), low=(0,0), one valid symbol -> 4 cycles later o_vld=1, o_sum=(100,-50), o_up=(100,-50), o_sat=0.
2. Load taps tap0=(4096,0), tap1=(0,4096), taps 2..4 = 0; feed up=(200,0) then zeros with low=0 -> consecutive outputs (100,0), then (0,100), then (0,0). o_coe_busy is high for 4 cycles during the load.
3. Load tap0=(32767,0), others 0; up=(511,0), low=(511,0) -> o_sum_I=2047 (saturated, 2044+511=2555 clipped), o_sat=1. Next input up=0, low=0 -> o_sum_I=0 and o_sat stays 1.
4. Unity taps; iq_val pattern 1,0,0,1,1 with up=10,20,30 on the valid cycles -> exactly 3 o_vld pulses carrying o_sum_I = 10, 20, 30. Each pulse is 4 cycles after its input, and the delay line shifts only 3 times.
5. Send 3 of 5 load_coe pulses, then preset_coe in the same cycle as a 4th load_coe -> o_coe_busy drops, active bank = unity, the next 5 loads fill a fresh bank, and up=(7,7) passes unchanged before the reload completes.
6. Assert reset for 1 cycle with 3 symbols in flight -> o_vld=0 in the next cycle and no stale outputs. The first post-reset symbol up=(-3,5) yields o_sum=(-3,5).

Source files
------------

// File: rtl/pcma_signal_combiner_if.sv
// Symbol, tap-load and status signals between a PCMA signal combiner and whatever drives it.
interface pcma_signal_combiner_if #(
  parameter int IQ_WIDTH    = 10,
  parameter int COE_WIDTH   = 16,
  parameter int OUT_D_WIDTH = 12
);
  logic                          iq_val;
  logic signed [IQ_WIDTH-1:0]    i_up_I;
  logic signed [IQ_WIDTH-1:0]    i_up_Q;
  logic signed [IQ_WIDTH-1:0]    i_low_I;
  logic signed [IQ_WIDTH-1:0]    i_low_Q;
  logic                          preset_coe;
  logic                          load_coe;
  logic signed [COE_WIDTH-1:0]   i_coe_I;
  logic signed [COE_WIDTH-1:0]   i_coe_Q;
  logic signed [OUT_D_WIDTH-1:0] o_sum_I;
  logic signed [OUT_D_WIDTH-1:0] o_sum_Q;
  logic signed [IQ_WIDTH-1:0]    o_up_I;
  logic signed [IQ_WIDTH-1:0]    o_up_Q;
  logic                          o_vld;
  logic                          o_sat;
  logic                          o_coe_busy;

  modport master (
    output iq_val, i_up_I, i_up_Q, i_low_I, i_low_Q,
    output preset_coe, load_coe, i_coe_I, i_coe_Q,
    input  o_sum_I, o_sum_Q, o_up_I, o_up_Q, o_vld, o_sat, o_coe_busy
  );

  modport slave (
    input  iq_val, i_up_I, i_up_Q, i_low_I, i_low_Q,
    input  preset_coe, load_coe, i_coe_I, i_coe_Q,
    output o_sum_I, o_sum_Q, o_up_I, o_up_Q, o_vld, o_sat, o_coe_busy
  );
endinterface

// File: rtl/pcma_signal_combiner.sv
// Composite PCMA transmit signal: sum = low + h*up through a CH_LEN-tap complex FIR,
// four-stage pipeline, double-buffered taps with atomic bank swap.
module pcma_signal_combiner #(
  parameter int IQ_WIDTH    = 10,
  parameter int COE_WIDTH   = 16,
  parameter int CH_LEN      = 5,
  parameter int OUT_D_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  pcma_signal_combiner_if.slave bus
);
  localparam int PROD_W = IQ_WIDTH + COE_WIDTH;
  localparam int ACC_W  = PROD_W + 1 + $clog2(CH_LEN);
  localparam int PTR_W  = $clog2(CH_LEN);
  localparam int FRAC_W = COE_WIDTH - 3;

  typedef logic signed [IQ_WIDTH-1:0]    iq_t;
  typedef logic signed [COE_WIDTH-1:0]   coe_t;
  typedef logic signed [PROD_W-1:0]      prod_t;
  typedef logic signed [ACC_W-1:0]       acc_t;
  typedef logic signed [OUT_D_WIDTH-1:0] out_t;
  typedef enum logic [0:0] {IDLE = 1'b0, LOADING = 1'b1} load_state_t;

  localparam coe_t UNITY   = coe_t'((32'sd1 <<< FRAC_W) - 32'sd1);
  localparam acc_t RND     = acc_t'(32'sd1 <<< (FRAC_W - 1));
  localparam acc_t SAT_MAX = acc_t'((32'sd1 <<< (OUT_D_WIDTH - 1)) - 32'sd1);

  // Returns {saturated, clipped value}; clipping is symmetric so -2^(N-1) never appears.
  function automatic logic [OUT_D_WIDTH:0] sat_fn(input acc_t v);
    if (v > SAT_MAX) begin
      sat_fn = {1'b1, out_t'(SAT_MAX)};
    end else if (v < -SAT_MAX) begin
      sat_fn = {1'b1, out_t'(-SAT_MAX)};
    end else begin
      sat_fn = {1'b0, out_t'(v)};
    end
  endfunction

  load_state_t      state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             commit_q, busy_q;
  coe_t sh_re_q [CH_LEN];
  coe_t sh_im_q [CH_LEN];
  coe_t act_re_q [CH_LEN];
  coe_t act_im_q [CH_LEN];

  // Tap loading: fill shadow, swap whole bank one edge after the last write; preset wins.
  always_ff @(posedge clk) begin
    if (reset || bus.preset_coe) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int k = 0; k < CH_LEN; k++) begin
        sh_re_q[k]  <= '0;
        sh_im_q[k]  <= '0;
        act_re_q[k] <= (k == 0) ? UNITY : '0;
        act_im_q[k] <= '0;
      end
    end else begin
      if (commit_q) begin
        act_re_q <= sh_re_q;
        act_im_q <= sh_im_q;
      end
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_coe) begin
            sh_re_q[ptr_q] <= bus.i_coe_I;
            sh_im_q[ptr_q] <= bus.i_coe_Q;
            ptr_q          <= ptr_q + 1'b1;
            busy_q         <= 1'b1;
            state_q        <= LOADING;
          end
        end
        LOADING: begin
          if (bus.load_coe) begin
            sh_re_q[ptr_q] <= bus.i_coe_I;
            sh_im_q[ptr_q] <= bus.i_coe_Q;
            if (ptr_q == PTR_W'(CH_LEN - 1)) begin
              ptr_q    <= '0;
              busy_q   <= 1'b0;
              commit_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              ptr_q  <= ptr_q + 1'b1;
              busy_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  iq_t   x_re_q [CH_LEN], x_im_q [CH_LEN], x_re_d [CH_LEN], x_im_d [CH_LEN];
  prod_t p_rr_q [CH_LEN], p_ii_q [CH_LEN], p_ri_q [CH_LEN], p_ir_q [CH_LEN];
  prod_t p_rr_d [CH_LEN], p_ii_d [CH_LEN], p_ri_d [CH_LEN], p_ir_d [CH_LEN];
  logic  v1_q, v2_q, v3_q, vld_q, v1_d, v2_d, v3_d, vld_d;
  iq_t   low1_re_q, low1_im_q, low2_re_q, low2_im_q, low3_re_q, low3_im_q;
  iq_t   low1_re_d, low1_im_d, low2_re_d, low2_im_d, low3_re_d, low3_im_d;
  iq_t   up2_re_q, up2_im_q, up3_re_q, up3_im_q, up_re_q, up_im_q;
  iq_t   up2_re_d, up2_im_d, up3_re_d, up3_im_d, up_re_d, up_im_d;
  acc_t  acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  acc_t  rnd_re_s, rnd_im_s;
  logic [OUT_D_WIDTH:0] sat_re_s, sat_im_s;
  out_t  sum_re_q, sum_im_q, sum_re_d, sum_im_d;
  logic  sat_q, sat_d;

  // Next-state for all four pipeline stages.
  always_comb begin
    x_re_d    = x_re_q;
    x_im_d    = x_im_q;
    low1_re_d = low1_re_q;
    low1_im_d = low1_im_q;
    v1_d      = bus.iq_val;
    if (bus.iq_val) begin
      x_re_d[0] = bus.i_up_I;
      x_im_d[0] = bus.i_up_Q;
      for (int k = 1; k < CH_LEN; k++) begin
        x_re_d[k] = x_re_q[k-1];
        x_im_d[k] = x_im_q[k-1];
      end
      low1_re_d = bus.i_low_I;
      low1_im_d = bus.i_low_Q;
    end else begin
      x_re_d = x_re_q;
      x_im_d = x_im_q;
    end

    for (int k = 0; k < CH_LEN; k++) begin
      p_rr_d[k] = prod_t'(act_re_q[k]) * prod_t'(x_re_q[k]);
      p_ii_d[k] = prod_t'(act_im_q[k]) * prod_t'(x_im_q[k]);
      p_ri_d[k] = prod_t'(act_re_q[k]) * prod_t'(x_im_q[k]);
      p_ir_d[k] = prod_t'(act_im_q[k]) * prod_t'(x_re_q[k]);
    end
    v2_d      = v1_q;
    low2_re_d = low1_re_q;
    low2_im_d = low1_im_q;
    up2_re_d  = x_re_q[0];
    up2_im_d  = x_im_q[0];

    acc_re_d = '0;
    acc_im_d = '0;
    for (int k = 0; k < CH_LEN; k++) begin
      acc_re_d = acc_re_d + acc_t'(p_rr_q[k]) - acc_t'(p_ii_q[k]);
      acc_im_d = acc_im_d + acc_t'(p_ri_q[k]) + acc_t'(p_ir_q[k]);
    end
    v3_d      = v2_q;
    low3_re_d = low2_re_q;
    low3_im_d = low2_im_q;
    up3_re_d  = up2_re_q;
    up3_im_d  = up2_im_q;

    rnd_re_s = (acc_re_q + RND) >>> FRAC_W;
    rnd_im_s = (acc_im_q + RND) >>> FRAC_W;
    sat_re_s = sat_fn(rnd_re_s + acc_t'(low3_re_q));
    sat_im_s = sat_fn(rnd_im_s + acc_t'(low3_im_q));
    vld_d    = v3_q;
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    up_re_d  = up_re_q;
    up_im_d  = up_im_q;
    sat_d    = sat_q;
    if (v3_q) begin
      sum_re_d = out_t'(sat_re_s[OUT_D_WIDTH-1:0]);
      sum_im_d = out_t'(sat_im_s[OUT_D_WIDTH-1:0]);
      up_re_d  = up3_re_q;
      up_im_d  = up3_im_q;
      sat_d    = sat_q | sat_re_s[OUT_D_WIDTH] | sat_im_s[OUT_D_WIDTH];
    end else begin
      sat_d = sat_q;
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH_LEN; k++) begin
        x_re_q[k] <= '0;
        x_im_q[k] <= '0;
        p_rr_q[k] <= '0;
        p_ii_q[k] <= '0;
        p_ri_q[k] <= '0;
        p_ir_q[k] <= '0;
      end
      {v1_q, v2_q, v3_q, vld_q, sat_q} <= 5'b0;
      {low1_re_q, low1_im_q, low2_re_q, low2_im_q, low3_re_q, low3_im_q} <= '0;
      {up2_re_q, up2_im_q, up3_re_q, up3_im_q, up_re_q, up_im_q} <= '0;
      {acc_re_q, acc_im_q, sum_re_q, sum_im_q} <= '0;
    end else begin
      x_re_q    <= x_re_d;
      x_im_q    <= x_im_d;
      p_rr_q    <= p_rr_d;
      p_ii_q    <= p_ii_d;
      p_ri_q    <= p_ri_d;
      p_ir_q    <= p_ir_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      vld_q     <= vld_d;
      sat_q     <= sat_d;
      low1_re_q <= low1_re_d;
      low1_im_q <= low1_im_d;
      low2_re_q <= low2_re_d;
      low2_im_q <= low2_im_d;
      low3_re_q <= low3_re_d;
      low3_im_q <= low3_im_d;
      up2_re_q  <= up2_re_d;
      up2_im_q  <= up2_im_d;
      up3_re_q  <= up3_re_d;
      up3_im_q  <= up3_im_d;
      up_re_q   <= up_re_d;
      up_im_q   <= up_im_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
    end
  end

  assign bus.o_sum_I    = sum_re_q;
  assign bus.o_sum_Q    = sum_im_q;
  assign bus.o_up_I     = up_re_q;
  assign bus.o_up_Q     = up_im_q;
  assign bus.o_vld      = vld_q;
  assign bus.o_sat      = sat_q;
  assign bus.o_coe_busy = busy_q;
endmodule

// File: tb/tb_pcma_signal_combiner.sv
// Bench for pcma_signal_combiner: directed scenarios plus randomized traffic against a queue-based model.
module tb_pcma_signal_combiner;
  localparam int IQW = 10;
  localparam int CW  = 16;
  localparam int CL  = 5;
  localparam int OW  = 12;

  typedef struct {int si; int sq; int ui; int uq; int due; bit sat;} exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errs   = 0;
  int   checks = 0;

  pcma_signal_combiner_if #(.IQ_WIDTH(IQW), .COE_WIDTH(CW), .OUT_D_WIDTH(OW)) bus ();

  pcma_signal_combiner #(.IQ_WIDTH(IQW), .COE_WIDTH(CW), .CH_LEN(CL), .OUT_D_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: taps as integers, upper-sample history as a newest-first queue.
  int  m_re [CL];
  int  m_im [CL];
  int  h_re [$];
  int  h_im [$];
  bit  m_sat;

  task automatic model_reset();
    for (int k = 0; k < CL; k++) begin
      m_re[k] = (k == 0) ? 8191 : 0;
      m_im[k] = 0;
    end
    h_re.delete();
    h_im.delete();
    m_sat = 1'b0;
  endtask

  function automatic longint round_q13(input longint y);
    longint t;
    longint r;
    t = y + 64'sd4096;
    r = t / 64'sd8192;
    if (t < 0 && (t % 64'sd8192) != 0) r = r - 1;
    return r;
  endfunction

  function automatic int clip(input longint v, output bit s);
    s = 1'b0;
    if (v > 2047) begin s = 1'b1; return 2047; end
    if (v < -2047) begin s = 1'b1; return -2047; end
    return int'(v);
  endfunction

  task automatic model_symbol(input int ui, input int uq, input int li, input int lq, output exp_t e);
    longint yr, yi;
    bit s1, s2;
    h_re.push_front(ui);
    h_im.push_front(uq);
    if (h_re.size() > CL) begin
      void'(h_re.pop_back());
      void'(h_im.pop_back());
    end
    yr = 0;
    yi = 0;
    for (int k = 0; k < h_re.size(); k++) begin
      yr += longint'(m_re[k]) * h_re[k] - longint'(m_im[k]) * h_im[k];
      yi += longint'(m_re[k]) * h_im[k] + longint'(m_im[k]) * h_re[k];
    end
    e.si  = clip(round_q13(yr) + li, s1);
    e.sq  = clip(round_q13(yi) + lq, s2);
    e.ui  = ui;
    e.uq  = uq;
    m_sat = m_sat | s1 | s2;
    e.sat = m_sat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int ui, input int uq, input int li, input int lq);
    bus.iq_val  = v;
    bus.i_up_I  = IQW'(ui);
    bus.i_up_Q  = IQW'(uq);
    bus.i_low_I = IQW'(li);
    bus.i_low_Q = IQW'(lq);
  endtask

  task automatic set_coe(input bit ld, input int ci, input int cq);
    bus.load_coe = ld;
    bus.i_coe_I  = CW'(ci);
    bus.i_coe_Q  = CW'(cq);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    set_coe(1'b0, 0, 0);
    bus.preset_coe = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_taps(input int tr [CL], input int ti [CL]);
    for (int k = 0; k < CL; k++) begin
      set_coe(1'b1, tr[k], ti[k]);
      tick();
    end
    set_coe(1'b0, 0, 0);
    tick();
    m_re = tr;
    m_im = ti;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_vld !== 1'b0) begin errs++; $display("FAIL reset_vld: got %0b want 0", bus.o_vld); end
    checks++; if (bus.o_sum_I !== 0 || bus.o_sum_Q !== 0) begin errs++; $display("FAIL reset_sum: got (%0d,%0d) want (0,0)", bus.o_sum_I, bus.o_sum_Q); end
    checks++; if (bus.o_up_I !== 0 || bus.o_up_Q !== 0) begin errs++; $display("FAIL reset_up: got (%0d,%0d) want (0,0)", bus.o_up_I, bus.o_up_Q); end
    checks++; if (bus.o_sat !== 1'b0 || bus.o_coe_busy !== 1'b0) begin errs++; $display("FAIL reset_flags: got sat=%0b busy=%0b want 0,0", bus.o_sat, bus.o_coe_busy); end
  endtask

  task automatic test_unity();
    do_reset();
    drive(1'b1, 100, -50, 0, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 0, 0, 0);
      checks++; if (bus.o_vld !== (c == 3)) begin errs++; $display("FAIL unity_latency c=%0d: got vld=%0b want %0b", c, bus.o_vld, c == 3); end
    end
    checks++; if (bus.o_sum_I !== 100 || bus.o_sum_Q !== -50) begin errs++; $display("FAIL unity_sum: got (%0d,%0d) want (100,-50)", bus.o_sum_I, bus.o_sum_Q); end
    checks++; if (bus.o_up_I !== 100 || bus.o_up_Q !== -50) begin errs++; $display("FAIL unity_up: got (%0d,%0d) want (100,-50)", bus.o_up_I, bus.o_up_Q); end
    checks++; if (bus.o_sat !== 1'b0) begin errs++; $display("FAIL unity_sat: got %0b want 0", bus.o_sat); end
  endtask

  task automatic test_load();
    int busy_cnt;
    int er [3];
    int ei [3];
    er = '{100, 0, 0};
    ei = '{0, 100, 0};
    do_reset();
    busy_cnt = 0;
    for (int k = 0; k < CL; k++) begin
      set_coe(1'b1, (k == 0) ? 4096 : 0, (k == 1) ? 4096 : 0);
      tick();
      if (bus.o_coe_busy === 1'b1) busy_cnt++;
      checks++; if (bus.o_coe_busy !== (k < CL - 1)) begin errs++; $display("FAIL load_busy k=%0d: got %0b want %0b", k, bus.o_coe_busy, k < CL - 1); end
    end
    set_coe(1'b0, 0, 0);
    tick();
    checks++; if (busy_cnt != 4) begin errs++; $display("FAIL load_busy_cycles: got %0d want 4", busy_cnt); end
    for (int c = 0; c < 6; c++) begin
      drive(c < 3, (c == 0) ? 200 : 0, 0, 0, 0);
      tick();
      checks++; if (bus.o_vld !== (c >= 3)) begin errs++; $display("FAIL load_vld c=%0d: got %0b want %0b", c, bus.o_vld, c >= 3); end
      if (c >= 3) begin
        checks++; if (bus.o_sum_I !== er[c-3] || bus.o_sum_Q !== ei[c-3]) begin errs++; $display("FAIL load_sum c=%0d: got (%0d,%0d) want (%0d,%0d)", c, bus.o_sum_I, bus.o_sum_Q, er[c-3], ei[c-3]); end
      end
    end
    drive(1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_sat();
    do_reset();
    load_taps('{32767, 0, 0, 0, 0}, '{0, 0, 0, 0, 0});
    for (int c = 0; c < 5; c++) begin
      drive(c < 2, (c == 0) ? 511 : 0, 0, (c == 0) ? 511 : 0, 0);
      tick();
      if (c == 3) begin
        checks++; if (bus.o_vld !== 1'b1 || bus.o_sum_I !== 2047 || bus.o_sum_Q !== 0) begin errs++; $display("FAIL sat_clip: got vld=%0b (%0d,%0d) want 1 (2047,0)", bus.o_vld, bus.o_sum_I, bus.o_sum_Q); end
        checks++; if (bus.o_sat !== 1'b1) begin errs++; $display("FAIL sat_flag: got %0b want 1", bus.o_sat); end
      end else if (c == 4) begin
        checks++; if (bus.o_vld !== 1'b1 || bus.o_sum_I !== 0) begin errs++; $display("FAIL sat_next: got vld=%0b sum_I=%0d want 1 0", bus.o_vld, bus.o_sum_I); end
        checks++; if (bus.o_sat !== 1'b1) begin errs++; $display("FAIL sat_sticky: got %0b want 1", bus.o_sat); end
      end
    end
    drive(1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_gaps();
    bit vpat [10];
    int upat [10];
    int pulses;
    vpat = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    upat = '{10, 0, 0, 20, 30, 0, 0, 0, 0, 0};
    do_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      drive(vpat[c], upat[c], 0, 0, 0);
      tick();
      if (bus.o_vld === 1'b1) pulses++;
      checks++; if (bus.o_vld !== (c == 3 || c == 6 || c == 7)) begin errs++; $display("FAIL gaps_vld c=%0d: got %0b", c, bus.o_vld); end
      if (c >= 3) begin
        checks++; if (bus.o_sum_I !== ((c < 6) ? 10 : (c == 6) ? 20 : 30)) begin errs++; $display("FAIL gaps_sum c=%0d: got %0d want %0d", c, bus.o_sum_I, (c < 6) ? 10 : (c == 6) ? 20 : 30); end
      end
    end
    checks++; if (pulses != 3) begin errs++; $display("FAIL gaps_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_preset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_coe(1'b1, 1000 + k, 0);
      tick();
    end
    checks++; if (bus.o_coe_busy !== 1'b1) begin errs++; $display("FAIL preset_partial_busy: got %0b want 1", bus.o_coe_busy); end
    set_coe(1'b1, 5, 5);
    bus.preset_coe = 1'b1;
    tick();
    bus.preset_coe = 1'b0;
    checks++; if (bus.o_coe_busy !== 1'b0) begin errs++; $display("FAIL preset_busy_drop: got %0b want 0", bus.o_coe_busy); end
    for (int k = 0; k < CL; k++) begin
      set_coe(1'b1, (k == 0) ? 4096 : 0, 0);
      drive(k == 0, 7, 7, 0, 0);
      tick();
      checks++; if (bus.o_coe_busy !== (k < CL - 1)) begin errs++; $display("FAIL preset_reload_busy k=%0d: got %0b", k, bus.o_coe_busy); end
      if (k == 3) begin
        checks++; if (bus.o_vld !== 1'b1 || bus.o_sum_I !== 7 || bus.o_sum_Q !== 7) begin errs++; $display("FAIL preset_unity: got vld=%0b (%0d,%0d) want 1 (7,7)", bus.o_vld, bus.o_sum_I, bus.o_sum_Q); end
      end
    end
    set_coe(1'b0, 0, 0);
    drive(1'b0, 0, 0, 0, 0);
    tick();
    drive(1'b1, 40, -20, 0, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 0, 0, 0);
    end
    checks++; if (bus.o_vld !== 1'b1 || bus.o_sum_I !== 20 || bus.o_sum_Q !== -10) begin errs++; $display("FAIL preset_newbank: got vld=%0b (%0d,%0d) want 1 (20,-10)", bus.o_vld, bus.o_sum_I, bus.o_sum_Q); end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 50 + k, 0, 0, 0);
      tick();
    end
    drive(1'b0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++; if (bus.o_vld !== 1'b0 || bus.o_sum_I !== 0) begin errs++; $display("FAIL midreset_vld: got vld=%0b sum_I=%0d want 0 0", bus.o_vld, bus.o_sum_I); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.o_vld !== 1'b0) begin errs++; $display("FAIL midreset_stale c=%0d: got vld=%0b want 0", c, bus.o_vld); end
    end
    drive(1'b1, -3, 5, 0, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b0, 0, 0, 0, 0);
    end
    checks++; if (bus.o_vld !== 1'b1 || bus.o_sum_I !== -3 || bus.o_sum_Q !== 5) begin errs++; $display("FAIL midreset_first: got vld=%0b (%0d,%0d) want 1 (-3,5)", bus.o_vld, bus.o_sum_I, bus.o_sum_Q); end
    checks++; if (bus.o_up_I !== -3 || bus.o_up_Q !== 5) begin errs++; $display("FAIL midreset_up: got (%0d,%0d) want (-3,5)", bus.o_up_I, bus.o_up_Q); end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    int   tr [CL];
    int   ti [CL];
    int   last_si, last_sq;
    bit   v, exp_v;
    int   ui, uq, li, lq;
    do_reset();
    for (int k = 0; k < CL; k++) begin
      tr[k] = int'($urandom_range(0, 8192)) - 4096;
      ti[k] = int'($urandom_range(0, 8192)) - 4096;
    end
    load_taps(tr, ti);
    last_si = 0;
    last_sq = 0;
    for (int c = 0; c < 304; c++) begin
      v  = (c < 300) && ($urandom_range(0, 3) != 0);
      ui = int'($urandom_range(0, 1023)) - 512;
      uq = int'($urandom_range(0, 1023)) - 512;
      li = int'($urandom_range(0, 1023)) - 512;
      lq = int'($urandom_range(0, 1023)) - 512;
      drive(v, ui, uq, li, lq);
      if (v) begin
        model_symbol(ui, uq, li, lq, e);
        e.due = c + 3;
        q.push_back(e);
      end
      tick();
      exp_v = (q.size() > 0) && (q[0].due == c);
      checks++; if (bus.o_vld !== exp_v) begin errs++; $display("FAIL rand_vld c=%0d: got %0b want %0b", c, bus.o_vld, exp_v); end
      if (exp_v) begin
        e = q.pop_front();
        last_si = e.si;
        last_sq = e.sq;
        checks++; if (bus.o_sum_I !== e.si || bus.o_sum_Q !== e.sq) begin errs++; $display("FAIL rand_sum c=%0d: got (%0d,%0d) want (%0d,%0d)", c, bus.o_sum_I, bus.o_sum_Q, e.si, e.sq); end
        checks++; if (bus.o_up_I !== e.ui || bus.o_up_Q !== e.uq) begin errs++; $display("FAIL rand_up c=%0d: got (%0d,%0d) want (%0d,%0d)", c, bus.o_up_I, bus.o_up_Q, e.ui, e.uq); end
        checks++; if (bus.o_sat !== e.sat) begin errs++; $display("FAIL rand_sat c=%0d: got %0b want %0b", c, bus.o_sat, e.sat); end
      end else begin
        checks++; if (bus.o_sum_I !== last_si || bus.o_sum_Q !== last_sq) begin errs++; $display("FAIL rand_hold c=%0d: got (%0d,%0d) want (%0d,%0d)", c, bus.o_sum_I, bus.o_sum_Q, last_si, last_sq); end
      end
    end
    checks++; if (q.size() != 0) begin errs++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.preset_coe = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    set_coe(1'b0, 0, 0);
    test_reset();
    test_unity();
    test_load();
    test_sat();
    test_gaps();
    test_preset();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
